// File: rtl/inverter_ctrl.sv
// -----------------------------------------------------------------------------
// inverter_ctrl
// Issue sequencer for a pipelined DOM-masked GF(2^4) inverter.
//
// Each cycle it issues at most one masked nibble to the inverter, together with
// fresh randomness. An issue needs a valid input vector, a valid randomness word
// and a free credit. Results come back INV_LATENCY cycles later and go into an
// output FIFO. The inverter has no stall input, so every result must already
// have a FIFO slot when it arrives. The credit counter reserves that slot at
// issue time.
//
// Ports
//   ClkxCI, RstxBI          clock (rising edge), asynchronous active-low reset
//   InValidxSI/InReadyxSO   masked input handshake, _XxDI carries the shares
//   RndValidxSI/RndReadyxSO randomness handshake, RndxDI =
//                           {Bmul3,Bmul2,Bmul1,Zmul3,Zmul2,Zmul1}
//   OutValidxSO/OutReadyxSI result handshake, _QxDO is the FIFO head
//   IdlexSO                 no transaction in flight or buffered
//   _InvXxDO, _Zmul*xDO,
//   _Bmul*xDO               drive to the inverter (zero when nothing issues)
//   _InvQxDI                result shares from the inverter
// -----------------------------------------------------------------------------
module inverter_ctrl #(
    parameter int SHARES      = 2,
    parameter int INV_LATENCY = 2,
    parameter int RND_DLY     = 1,
    parameter int DEPTH       = 4,
    localparam int Z = SHARES * (SHARES - 1),
    localparam int B = 2 * SHARES,
    localparam int R = 3 * Z + 3 * B,
    localparam int W = 4 * SHARES
) (
    input  logic         ClkxCI,
    input  logic         RstxBI,
    input  logic         InValidxSI,
    output logic         InReadyxSO,
    input  logic [W-1:0] _XxDI,
    input  logic         RndValidxSI,
    output logic         RndReadyxSO,
    input  logic [R-1:0] RndxDI,
    output logic         OutValidxSO,
    input  logic         OutReadyxSI,
    output logic [W-1:0] _QxDO,
    output logic         IdlexSO,
    output logic [W-1:0] _InvXxDO,
    output logic [Z-1:0] _Zmul1xDO,
    output logic [Z-1:0] _Zmul2xDO,
    output logic [Z-1:0] _Zmul3xDO,
    output logic [B-1:0] _Bmul1xDO,
    output logic [B-1:0] _Bmul2xDO,
    output logic [B-1:0] _Bmul3xDO,
    input  logic [W-1:0] _InvQxDI
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW    = 2 * Z + 2 * B;

    // Credit and FIFO state
    logic [CNT_W-1:0]       cntReg;
    logic [CNT_W-1:0]       fifoCntReg;
    logic [PTR_W-1:0]       wrPtrReg;
    logic [PTR_W-1:0]       rdPtrReg;
    logic [W-1:0]           fifoMem [DEPTH];
    logic [INV_LATENCY-1:0] validPipeReg;

    logic pop;
    logic ok;
    logic issue;
    logic fifoWr;

    // Randomness for the later inverter stages: {Bmul3,Bmul2,Zmul3,Zmul2}
    logic [DW-1:0] dlyIn;
    logic [DW-1:0] dlyOut;

    // ------------------------------------------------------------------
    // Handshake and credit logic
    // ------------------------------------------------------------------
    assign OutValidxSO = (fifoCntReg != '0);
    assign pop         = OutValidxSO & OutReadyxSI;

    // A pop in this cycle frees a slot, so a full credit pool can still
    // accept. This keeps the throughput at one per cycle under a steady drain.
    assign ok = (cntReg < CNT_W'(DEPTH)) | pop;

    // Gating with RstxBI holds the readies and the inverter drive at zero
    // for the whole reset period, not only from the next edge.
    assign InReadyxSO  = RstxBI & RndValidxSI & ok;
    assign RndReadyxSO = RstxBI & InValidxSI & ok;
    assign issue       = RstxBI & InValidxSI & RndValidxSI & ok;

    assign IdlexSO = (cntReg == '0);

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            cntReg <= '0;
        end else begin
            cntReg <= cntReg + CNT_W'(issue) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Inverter drive: first-stage operands are combinational on issue
    // ------------------------------------------------------------------
    always_comb begin
        _InvXxDO  = '0;
        _Zmul1xDO = '0;
        _Bmul1xDO = '0;
        dlyIn     = '0;
        if (issue) begin
            _InvXxDO  = _XxDI;
            _Zmul1xDO = RndxDI[Z-1:0];
            _Bmul1xDO = RndxDI[3*Z+B-1:3*Z];
            dlyIn     = {RndxDI[3*Z+3*B-1:3*Z+2*B],   // Bmul3
                         RndxDI[3*Z+2*B-1:3*Z+B],     // Bmul2
                         RndxDI[3*Z-1:2*Z],           // Zmul3
                         RndxDI[2*Z-1:Z]};            // Zmul2
        end
    end

    // The later-stage randomness is delayed to the stage that uses it. A
    // non-issue cycle loads zeros, so no word is ever presented twice.
    generate
        if (RND_DLY == 0) begin : g_noDly
            assign dlyOut = dlyIn;
        end else begin : g_dly
            logic [DW-1:0] dlyChainReg [RND_DLY];
            for (genvar gi = 0; gi < RND_DLY; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge ClkxCI or negedge RstxBI) begin
                        if (!RstxBI) begin
                            dlyChainReg[gi] <= '0;
                        end else begin
                            dlyChainReg[gi] <= dlyIn;
                        end
                    end
                end else begin : g_body
                    always_ff @(posedge ClkxCI or negedge RstxBI) begin
                        if (!RstxBI) begin
                            dlyChainReg[gi] <= '0;
                        end else begin
                            dlyChainReg[gi] <= dlyChainReg[gi-1];
                        end
                    end
                end
            end
            assign dlyOut = dlyChainReg[RND_DLY-1];
        end
    endgenerate

    assign _Zmul2xDO = dlyOut[Z-1:0];
    assign _Zmul3xDO = dlyOut[2*Z-1:Z];
    assign _Bmul2xDO = dlyOut[2*Z+B-1:2*Z];
    assign _Bmul3xDO = dlyOut[2*Z+2*B-1:2*Z+B];

    // ------------------------------------------------------------------
    // In-flight tracking: the tail bit marks the cycle the result arrives
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < INV_LATENCY; gi++) begin : g_validPipe
            if (gi == 0) begin : g_head
                always_ff @(posedge ClkxCI or negedge RstxBI) begin
                    if (!RstxBI) begin
                        validPipeReg[gi] <= 1'b0;
                    end else begin
                        validPipeReg[gi] <= issue;
                    end
                end
            end else begin : g_body
                always_ff @(posedge ClkxCI or negedge RstxBI) begin
                    if (!RstxBI) begin
                        validPipeReg[gi] <= 1'b0;
                    end else begin
                        validPipeReg[gi] <= validPipeReg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign fifoWr = validPipeReg[INV_LATENCY-1];

    // ------------------------------------------------------------------
    // Output FIFO (circular). Credits guarantee a write never finds it full.
    // The head is read straight from the storage, so the inverter result
    // reaches _QxDO only after it has been registered.
    // ------------------------------------------------------------------
    always_ff @(posedge ClkxCI) begin
        if (fifoWr) begin
            fifoMem[wrPtrReg] <= _InvQxDI;
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            fifoCntReg <= '0;
        end else begin
            if (fifoWr) begin
                wrPtrReg <= (wrPtrReg == PTR_W'(DEPTH - 1)) ? '0 : wrPtrReg + 1'b1;
            end
            if (pop) begin
                rdPtrReg <= (rdPtrReg == PTR_W'(DEPTH - 1)) ? '0 : rdPtrReg + 1'b1;
            end
            fifoCntReg <= fifoCntReg + CNT_W'(fifoWr) - CNT_W'(pop);
        end
    end

    assign _QxDO = fifoMem[rdPtrReg];

endmodule
